// File: rtl/pwm_duty_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_gen
// Purpose  : Tick-driven PWM generator. A divider supplies a one-cycle tick
//            strobe; the period counter advances only on ticks. The duty value
//            is accepted over a valid/ready handshake and applied only at a
//            period boundary, so a running period is never truncated.
// Ports    : pxCLK        - system clock, all logic on the rising edge
//            reset        - asynchronous active-low reset
//            tick         - one-cycle counting strobe from the divider
//            run          - level start/stop request, sampled on tick
//            duty_valid   - duty_in is valid
//            duty_in      - requested high-ticks per period (clamped to PERIOD)
//            duty_ready   - a new duty can be accepted
//            pwm_out      - PWM output
//            period_start - one-cycle pulse when a period begins
//            active       - high while the generator is in RUN or STOP
// Options  : PWM_SOFTSTART_EN - when defined, the handshake writes a target
//            and the applied duty ramps by one tick per period toward it.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_gen #(
    parameter int PERIOD = 200,
    parameter int CNT_W  = 8,
    parameter int DUTY_W = 8
) (
    input  logic              pxCLK,
    input  logic              reset,
    input  logic              tick,
    input  logic              run,
    input  logic              duty_valid,
    input  logic [DUTY_W-1:0] duty_in,
    output logic              duty_ready,
    output logic              pwm_out,
    output logic              period_start,
    output logic              active
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] c_full = CNT_W'(PERIOD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_boundary;
    logic             w_wrap;
    logic             r_period_start;
    logic [CNT_W-1:0] r_duty_act;
    logic [CNT_W-1:0] w_duty_clamped;
    logic             w_xfer;

    assign w_wrap = (r_cnt == c_last);

    // Requests above PERIOD saturate to a full-high period.
    assign w_duty_clamped = (32'(duty_in) > 32'(PERIOD)) ? c_full : CNT_W'(duty_in);

    assign w_xfer = duty_valid && duty_ready;

    // ------------------------------------------------------------------------
    // Next-state / counter logic. Nothing moves except on a tick cycle.
    // A boundary is either the IDLE->RUN start or a wrap while running; both
    // produce a period_start pulse and a duty update.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_boundary  = 1'b0;
        if (tick) begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = '0;
                    if (run) begin
                        w_state_nxt = S_RUN;
                        w_boundary  = 1'b1;
                    end
                end
                S_RUN, S_STOP: begin
                    if ((r_state == S_STOP) && !run && w_wrap) begin
                        // Stop completes: last tick of the period, no new period.
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        // Re-asserting run during STOP just resumes counting,
                        // so the period cadence is unbroken.
                        w_state_nxt = run ? S_RUN : S_STOP;
                        if (w_wrap) begin
                            w_cnt_nxt  = '0;
                            w_boundary = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge pxCLK or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_period_start <= w_boundary;
        end
    end

`ifdef PWM_SOFTSTART_EN
    // ------------------------------------------------------------------------
    // Soft-start: handshake sets a target; the applied duty walks one step
    // per boundary toward it. A new target is taken only once it is reached.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_target;

    always_ff @(posedge pxCLK or negedge reset) begin
        if (!reset) begin
            r_target   <= '0;
            r_duty_act <= '0;
        end else begin
            if (w_xfer) begin
                r_target <= w_duty_clamped;
            end
            if (w_boundary) begin
                if (r_duty_act < r_target) begin
                    r_duty_act <= r_duty_act + 1'b1;
                end else if (r_duty_act > r_target) begin
                    r_duty_act <= r_duty_act - 1'b1;
                end
            end
        end
    end

    assign duty_ready = (r_duty_act == r_target);
`else
    // ------------------------------------------------------------------------
    // Shadow load: one pending value, applied whole at the next boundary.
    // Transfer and load are exclusive since one needs pending low, the other
    // pending high.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;

    always_ff @(posedge pxCLK or negedge reset) begin
        if (!reset) begin
            r_shadow   <= '0;
            r_pending  <= 1'b0;
            r_duty_act <= '0;
        end else begin
            if (w_boundary && r_pending) begin
                r_duty_act <= r_shadow;
                r_pending  <= 1'b0;
            end
            if (w_xfer) begin
                r_shadow  <= w_duty_clamped;
                r_pending <= 1'b1;
            end
        end
    end

    assign duty_ready = !r_pending;
`endif

    // Outputs decode registers only, so reset clears them immediately.
    assign active       = (r_state != S_IDLE);
    assign pwm_out      = active && (r_cnt < r_duty_act);
    assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_duty_gen
// Purpose  : Directed self-checking bench for pwm_duty_gen with PERIOD=10 and
//            one tick every 4 clocks. Counts high ticks and period_start
//            pulses over windows of ticks and compares them with hand-computed
//            values. With PWM_SOFTSTART_EN defined the ramp sequence is run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_gen;

    localparam int PERIOD = 10;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       tick       = 1'b0;
    logic       run        = 1'b0;
    logic       duty_valid = 1'b0;
    logic [7:0] duty_in    = 8'd0;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_start;
    logic       active;

    int n_chk  = 0;
    int n_err  = 0;
    int g_high = 0;
    int g_ps   = 0;

    pwm_duty_gen #(
        .PERIOD (PERIOD),
        .CNT_W  (8),
        .DUTY_W (8)
    ) dut (
        .pxCLK        (clk),
        .reset        (reset_n),
        .tick         (tick),
        .run          (run),
        .duty_valid   (duty_valid),
        .duty_in      (duty_in),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .active       (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        g_high = 0;
        g_ps   = 0;
    endtask

    // Called at a falling edge; issues one tick and returns 4 clocks later.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            g_high += int'(pwm_out);
            g_ps   += int'(period_start);
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic write_duty(input logic [7:0] v);
        duty_valid = 1'b1;
        duty_in    = v;
        @(negedge clk);
        duty_valid = 1'b0;
    endtask

`ifdef PWM_SOFTSTART_EN
    int exp_high [5] = '{1, 2, 3, 4, 4};
    int exp_rdy  [5] = '{0, 0, 0, 1, 1};
`endif

    initial begin
        repeat (2) @(negedge clk);
        check("rst_pwm",    pwm_out,      0);
        check("rst_active", active,       0);
        check("rst_ps",     period_start, 0);
        check("rst_ready",  duty_ready,   1);
        reset_n = 1'b1;
        @(negedge clk);

`ifdef PWM_SOFTSTART_EN
        write_duty(8'd4);
        check("ss_ready_busy", duty_ready, 0);
        run = 1'b1;
        for (int p = 0; p < 5; p++) begin
            clr();
            run_ticks(1);
            check($sformatf("ss_ready_p%0d", p), duty_ready, exp_rdy[p]);
            run_ticks(9);
            check($sformatf("ss_high_p%0d", p), g_high, exp_high[p]);
            check($sformatf("ss_ps_p%0d", p),   g_ps,   1);
        end
`else
        // 1: duty 3, steady periods
        write_duty(8'd3);
        check("t1_ready_pending", duty_ready, 0);
        run = 1'b1;
        clr();
        run_ticks(1);
        check("t1_ready_after_start", duty_ready, 1);
        check("t1_active", active, 1);
        run_ticks(9);
        check("t1_high_p0", g_high, 3);
        check("t1_ps_p0",   g_ps,   1);
        clr();
        run_ticks(10);
        check("t1_high_p1", g_high, 3);
        check("t1_ps_p1",   g_ps,   1);

        // 2: write 7 mid-period (cnt=5), applied at next boundary
        clr();
        run_ticks(6);
        write_duty(8'd7);
        check("t2_ready_low", duty_ready, 0);
        run_ticks(4);
        check("t2_ready_held", duty_ready, 0);
        check("t2_high_old", g_high, 3);
        clr();
        run_ticks(1);
        check("t2_ready_rise", duty_ready, 1);
        run_ticks(9);
        check("t2_high_new", g_high, 7);
        check("t2_ps_new",   g_ps,   1);

        // 3: zero duty, then over-range duty clamped to full period
        write_duty(8'd0);
        clr();
        run_ticks(10);
        check("t3_high_zero", g_high, 0);
        check("t3_ps_zero",   g_ps,   1);
        write_duty(8'd15);
        clr();
        run_ticks(10);
        check("t3_high_clamp", g_high, 10);

        // 4: stop at cnt=4 finishes the period, then idles
        clr();
        run_ticks(5);
        run = 1'b0;
        clr();
        run_ticks(5);
        check("t4_stop_active", active, 1);
        check("t4_stop_high",   g_high, 5);
        run_ticks(1);
        check("t4_stop_no_ps", g_ps,    0);
        check("t4_idle_active", active, 0);
        check("t4_idle_pwm",   pwm_out, 0);

        // 4b: resume during STOP keeps the period cadence
        write_duty(8'd3);
        run = 1'b1;
        run_ticks(1);
        clr();
        run_ticks(4);
        run = 1'b0;
        run_ticks(3);
        check("t4_resume_active", active, 1);
        run = 1'b1;
        run_ticks(2);
        check("t4_resume_no_early_ps", g_ps, 0);
        run_ticks(1);
        check("t4_resume_ps", g_ps, 1);
        clr();
        run_ticks(10);
        check("t4_resume_ps_next", g_ps,   1);
        check("t4_resume_high",    g_high, 3);

        // 5: reset at cnt=6 with output high and a write pending
        write_duty(8'd8);
        run_ticks(10);
        run_ticks(6);
        check("t5_pwm_pre", pwm_out, 1);
        write_duty(8'd9);
        check("t5_ready_pre", duty_ready, 0);
        reset_n = 1'b0;
        #1;
        check("t5_rst_pwm",    pwm_out,      0);
        check("t5_rst_active", active,       0);
        check("t5_rst_ready",  duty_ready,   1);
        check("t5_rst_ps",     period_start, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clr();
        run_ticks(10);
        check("t5_restart_high",   g_high, 0);
        check("t5_restart_ps",     g_ps,   1);
        check("t5_restart_active", active, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
